serial_adder: RTL

Bit-serial N-bit adder. It sequences one existing FA cell LSB-first across two latched operands, holding the carry in a flop between bits. It sits directly upstream of FA: it drives FA x/y/Cin and consumes FA S/Cout. It is the low-area alternative to a ripple chain for arithmetic datapaths in the same design.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_fa.sv | 13 +
 rtl/serial_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and counter sizing for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell sequenced by serial_adder.
module serial_adder_fa (
    input  logic x,
    input  logic y,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = x ^ y ^ Cin;
    assign Cout = (x & y) | (Cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one FA cell walks LSB-first across latched operands,
// carry held in a flop; result, carry-out and signed overflow registered at the end.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-2:0] r_psum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_psum_nxt;

    serial_adder_fa u_fa (
        .x    (r_opa[0]),
        .y    (r_opb[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    // Partial sum keeps only WIDTH-1 bits; the final FA output supplies the MSB.
    assign w_psum_nxt = {w_s, r_psum};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_carry <= w_cout;
            r_psum  <= w_psum_nxt[WIDTH-1:1];
            // Explicit wrap keeps non-power-of-two widths inside 0..WIDTH-1.
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_psum_nxt;
                r_cout <= w_cout;
                r_ovf  <= r_carry ^ w_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
